// File: rtl/brightness_offset_pipe_pkg.sv
// Shared constants and types for the brightness offset pixel stage.
// Level range and pixel limits derive from the default widths.
package brightness_offset_pipe_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int STEP_W_DEF = 3;
  localparam int SHIFT_DEF  = 4;

  localparam int PIX_MAX   = (1 << PIX_W_DEF) - 1;
  localparam int LEVEL_MAX = (1 << STEP_W_DEF) - 1;

  typedef logic signed [STEP_W_DEF:0] level_t;

endpackage

// File: rtl/brightness_offset_pipe_sat_addsub.sv
// Saturating unsigned add/subtract of a magnitude to a pixel.
// Subtract uses a + ~mag + 1, so carry out means no borrow.
module sat_addsub_u8 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] mag,
  input  logic         neg,
  output logic [W-1:0] y
);

  logic [W:0]   c;
  logic [W-1:0] b;
  logic [W-1:0] s;

  assign b    = mag ^ {W{neg}};
  assign c[0] = neg;

  for (genvar i = 0; i < W; i++) begin : g_rca
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  always_comb begin
    if (neg) y = c[W] ? s : '0;
    else     y = c[W] ? '1 : s;
  end

endmodule

// File: rtl/brightness_offset_pipe.sv
// Two-stage pixel pipeline applying a signed brightness offset.
// The level only changes after the last beat of a frame.
module brightness_offset_pipe
  import brightness_offset_pipe_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_data,
  output logic              m_last,
  output logic [STEP_W:0]   level
);

  localparam int LMAX = (1 << STEP_W) - 1;
  localparam logic signed [STEP_W:0] LV_MAX = (STEP_W+1)'(LMAX);
  localparam logic signed [STEP_W:0] LV_MIN = -LV_MAX;
  localparam logic signed [STEP_W:0] ONE    = (STEP_W+1)'(1);

  logic signed [STEP_W:0] pending;
  logic signed [STEP_W:0] pending_nxt;
  logic signed [STEP_W:0] applied;
  logic [STEP_W:0]        abs_lvl;
  logic [PIX_W-1:0]       mag;
  logic                   en;
  logic                   acc_last;

  logic                   s1_v;
  logic [PIX_W-1:0]       s1_pix;
  logic                   s1_last;
  logic                   s1_neg;
  logic [PIX_W-1:0]       s1_mag;
  logic [PIX_W-1:0]       y;

  assign en       = !m_valid | m_ready;
  assign s_ready  = en;
  assign acc_last = s_valid & en & s_last;
  assign level    = applied;
  assign abs_lvl  = applied[STEP_W] ? -applied : applied;
  assign mag      = PIX_W'(abs_lvl) << SHIFT;

  always_comb begin
    pending_nxt = pending;
    if (btn_up && !btn_down && pending != LV_MAX)
      pending_nxt = pending + ONE;
    else if (btn_down && !btn_up && pending != LV_MIN)
      pending_nxt = pending - ONE;
  end

  // a press coinciding with the frame-end beat lands in the new level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      applied <= '0;
    end else begin
      pending <= pending_nxt;
      if (acc_last) applied <= pending_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_pix  <= '0;
      s1_last <= 1'b0;
      s1_neg  <= 1'b0;
      s1_mag  <= '0;
    end else if (en) begin
      s1_v <= s_valid;
      if (s_valid) begin
        s1_pix  <= s_data;
        s1_last <= s_last;
        s1_neg  <= applied[STEP_W];
        s1_mag  <= mag;
      end
    end
  end

  sat_addsub_u8 #(.W(PIX_W)) u_sat (
    .a   (s1_pix),
    .mag (s1_mag),
    .neg (s1_neg),
    .y   (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (en) begin
      m_valid <= s1_v;
      if (s1_v) begin
        m_data <= y;
        m_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_brightness_offset_pipe.sv
// Directed bench with a frame-level reference model and scoreboard.
// Hand-computed pixel results pin the model and the 2-cycle latency.
module tb_brightness_offset_pipe;

  logic       clk = 0;
  logic       rst = 1;
  logic       btn_up = 0;
  logic       btn_down = 0;
  logic       s_valid = 0;
  logic       s_ready;
  logic [7:0] s_data = 0;
  logic       s_last = 0;
  logic       m_valid;
  logic       m_ready = 1;
  logic [7:0] m_data;
  logic       m_last;
  logic [3:0] level;

  int checks = 0;
  int errors = 0;

  int q[$];
  int pend = 0;
  int appl = 0;
  bit stall_prev = 0;
  int prev_d = 0;
  int prev_l = 0;

  brightness_offset_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model(input int pix, input int lvl);
    int v;
    v = pix + lvl * 16;
    if (v > 255) v = 255;
    if (v < 0) v = 0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_level", int'($signed(level)), 0);
      q.delete();
      pend = 0;
      appl = 0;
      stall_prev = 0;
    end else begin
      chk("level", int'($signed(level)), appl);
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_d);
        chk("stall_last", m_last, prev_l);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got data %0d, expected no beat", m_data);
        end else begin
          int e;
          e = q.pop_front();
          checks++;
          if (m_data != e % 256 || m_last != e / 256) begin
            errors++;
            $display("FAIL out_beat: got %0d/%0d, expected %0d/%0d",
                     m_data, m_last, e % 256, e / 256);
          end
        end
      end
      if (m_valid && !m_ready) chk("stall_sready", s_ready, 0);
      if (s_valid && s_ready)
        q.push_back(model(s_data, appl) + 256 * s_last);
      if (btn_up && !btn_down && pend < 7) pend++;
      else if (btn_down && !btn_up && pend > -7) pend--;
      if (s_valid && s_ready && s_last) appl = pend;
      stall_prev = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up, input bit dn);
    btn_up = up;
    btn_down = dn;
    step();
    btn_up = 0;
    btn_down = 0;
  endtask

  task automatic beat(input int d, input bit last);
    int n;
    n = 0;
    s_valid = 1;
    s_data = 8'(d);
    s_last = last;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("beat_timeout", n, 0);
    step();
    s_valid = 0;
    s_last = 0;
  endtask

  // single isolated pixel: also pins the two-cycle latency
  task automatic one(input int d, input bit last, input int exp,
                     input bit up);
    s_valid = 1;
    s_data = 8'(d);
    s_last = last;
    btn_up = up;
    step();
    s_valid = 0;
    s_last = 0;
    btn_up = 0;
    @(negedge clk);
    chk("lat_early", m_valid, 0);
    step();
    @(negedge clk);
    chk("lat_valid", m_valid, 1);
    chk("pix", m_data, exp);
    chk("pix_last", m_last, last);
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    step();

    beat(0, 0);
    beat(128, 0);
    beat(255, 1);
    repeat (3) step();
    one(0, 0, 0, 0);
    one(128, 0, 128, 0);
    one(255, 1, 255, 0);

    repeat (3) press(1, 0);
    chk("lvl_before_eof", int'($signed(level)), 0);
    one(10, 1, 10, 0);
    chk("lvl_up3", int'($signed(level)), 3);
    one(200, 0, 248, 0);
    one(220, 1, 255, 0);

    repeat (10) press(0, 1);
    one(50, 1, 98, 0);
    chk("lvl_dn7", int'($signed(level)), -7);
    one(100, 0, 0, 0);
    one(150, 0, 38, 0);
    one(150, 1, 38, 0);

    press(1, 1);
    one(1, 1, 0, 0);
    chk("lvl_both", int'($signed(level)), -7);

    press(1, 0);
    one(200, 0, 88, 0);
    chk("lvl_midframe", int'($signed(level)), -7);
    one(200, 1, 88, 0);
    chk("lvl_m6", int'($signed(level)), -6);
    one(200, 0, 104, 0);
    one(200, 1, 104, 1);
    chk("lvl_eof_press", int'($signed(level)), -5);
    one(200, 0, 120, 0);

    fork
      begin
        for (int i = 0; i < 8; i++) beat(10 + i * 20, i == 7);
      end
      begin
        repeat (3) step();
        m_ready = 0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_s_ready", s_ready, 0);
          step();
        end
        m_ready = 1;
      end
    join
    repeat (5) step();
    chk("drain", q.size(), 0);

    m_ready = 0;
    beat(77, 0);
    repeat (3) step();
    chk("pre_rst_valid", m_valid, 1);
    rst = 1;
    #1;
    chk("rst_async_valid", m_valid, 0);
    chk("rst_async_level", int'($signed(level)), 0);
    repeat (2) step();
    rst = 0;
    m_ready = 1;
    step();
    one(77, 1, 77, 0);
    chk("lvl_after_rst", int'($signed(level)), 0);
    repeat (3) step();
    chk("final_drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
